// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch-target buffer.
// Holds the counter encodings, default geometry and the counter update helper.
package btb_predictor_pkg;

    localparam logic [1:0] BTB_SNT = 2'b00;
    localparam logic [1:0] BTB_WNT = 2'b01;
    localparam logic [1:0] BTB_WT  = 2'b10;
    localparam logic [1:0] BTB_ST  = 2'b11;

    localparam int BTB_PC_W  = 13;
    localparam int BTB_IDX_W = 9;
    localparam int BTB_LANES = 2;

    // Saturating two-bit counter step toward the observed outcome.
    function automatic logic [1:0] ctr_next(logic [1:0] c, logic taken);
        if (taken)
            return (c == BTB_ST) ? BTB_ST : c + 2'd1;
        else
            return (c == BTB_SNT) ? BTB_SNT : c - 2'd1;
    endfunction

    function automatic int lane_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch/resolve bundle of the branch-target buffer.
// master: fetch + resolve side (drives lk_*, upd_*, flush); slave: the BTB.
interface btb_predictor_if
    import btb_predictor_pkg::*;
#(
    parameter int PC_W   = BTB_PC_W,
    parameter int LANES  = BTB_LANES,
    parameter int LANE_W = lane_w(LANES)
);
    logic                  lk_valid;
    logic [LANES*PC_W-1:0] lk_pc;
    logic [LANES-1:0]      hit;
    logic [LANES*PC_W-1:0] target;
    logic [LANES*2-1:0]    state;
    logic                  any_hit;
    logic [LANE_W-1:0]     first_lane;
    logic                  upd_valid;
    logic [PC_W-1:0]       upd_pc;
    logic                  upd_taken;
    logic [PC_W-1:0]       upd_target;
    logic                  flush;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  hit, target, state, any_hit, first_lane
    );

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output hit, target, state, any_hit, first_lane
    );
endinterface

// File: rtl/btb_predictor_lane.sv
// One lookup lane: tag compare, optional same-cycle update bypass, output register.
// Ports: CLK/NRST, lookup pc, entry read data (rd_*), pending write (wr_*),
// registered hit/target/state. Bypass built when BTB_BYPASS_EN is defined.
module btb_lane
    import btb_predictor_pkg::*;
#(
    parameter int PC_W  = BTB_PC_W,
    parameter int IDX_W = BTB_IDX_W,
    localparam int TAG_W = PC_W - IDX_W
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             lk_valid,
    input  logic             flush,
    input  logic [PC_W-1:0]  pc,
    input  logic             rd_valid,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic [PC_W-1:0]  rd_tgt,
    input  logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_tgt,
    input  logic [1:0]       wr_ctr,
    output logic             hit,
    output logic [PC_W-1:0]  target,
    output logic [1:0]       state
);
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [PC_W-1:0]  e_tgt;
    logic [1:0]       e_ctr;
    logic             match;

    always_comb begin
        e_valid = rd_valid;
        e_tag   = rd_tag;
        e_tgt   = rd_tgt;
        e_ctr   = rd_ctr;
`ifdef BTB_BYPASS_EN
        // Forward the entry being written this edge so the lookup sees it.
        if (wr_en && wr_idx == pc[IDX_W-1:0]) begin
            e_valid = 1'b1;
            e_tag   = wr_tag;
            e_tgt   = wr_tgt;
            e_ctr   = wr_ctr;
        end
`endif
    end

`ifndef BTB_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{wr_en, wr_idx, wr_tag, wr_tgt, wr_ctr};
`endif

    // A flush in the same cycle invalidates everything, so the lookup misses.
    assign match = lk_valid && !flush && e_valid
                 && (e_tag == pc[PC_W-1:IDX_W]);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            hit    <= 1'b0;
            target <= '0;
            state  <= BTB_SNT;
        end else begin
            hit    <= match && e_ctr[1];
            target <= match ? e_tgt : '0;
            state  <= match ? e_ctr : BTB_SNT;
        end
    end
endmodule

// File: rtl/btb_predictor.sv
// Multi-lane branch-target buffer: storage, update read-modify-write, flush,
// first-taken priority encoder. Ports: CLK, NRST, bus (btb_predictor_if.slave).
// Optional macro BTB_BYPASS_EN forwards same-cycle updates to lookups.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int PC_W  = BTB_PC_W,
    parameter int IDX_W = BTB_IDX_W,
    parameter int LANES = BTB_LANES
) (
    input  logic CLK,
    input  logic NRST,
    btb_predictor_if.slave bus
);
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int LANE_W  = lane_w(LANES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_m [ENTRIES];
    logic [PC_W-1:0]    tgt_m [ENTRIES];
    logic [1:0]         ctr_m [ENTRIES];

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             wr_en;
    logic [PC_W-1:0]  wr_tgt;
    logic [1:0]       wr_ctr;

    assign u_idx = bus.upd_pc[IDX_W-1:0];
    assign u_tag = bus.upd_pc[PC_W-1:IDX_W];
    assign u_hit = valid_q[u_idx] && (tag_m[u_idx] == u_tag);

    // Hits train in place; taken misses allocate; not-taken misses are dropped.
    assign wr_en  = bus.upd_valid && !bus.flush && (u_hit || bus.upd_taken);
    assign wr_ctr = u_hit ? ctr_next(ctr_m[u_idx], bus.upd_taken) : BTB_WT;
    assign wr_tgt = bus.upd_taken ? bus.upd_target : tgt_m[u_idx];

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)
            valid_q <= '0;
        else if (bus.flush)
            valid_q <= '0;
        else if (wr_en)
            valid_q[u_idx] <= 1'b1;
    end

    // Payload is not reset; an entry is only observed once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (wr_en && NRST) begin
            tag_m[u_idx] <= u_tag;
            tgt_m[u_idx] <= wr_tgt;
            ctr_m[u_idx] <= wr_ctr;
        end
    end

    logic [LANES-1:0]      hit_v;
    logic [LANES*PC_W-1:0] tgt_v;
    logic [LANES*2-1:0]    st_v;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PC_W-1:0]  l_pc;
        logic [IDX_W-1:0] l_idx;

        assign l_pc  = bus.lk_pc[i*PC_W +: PC_W];
        assign l_idx = l_pc[IDX_W-1:0];

        btb_lane #(
            .PC_W  (PC_W),
            .IDX_W (IDX_W)
        ) u_lane (
            .CLK      (CLK),
            .NRST     (NRST),
            .lk_valid (bus.lk_valid),
            .flush    (bus.flush),
            .pc       (l_pc),
            .rd_valid (valid_q[l_idx]),
            .rd_tag   (tag_m[l_idx]),
            .rd_tgt   (tgt_m[l_idx]),
            .rd_ctr   (ctr_m[l_idx]),
            .wr_en    (wr_en),
            .wr_idx   (u_idx),
            .wr_tag   (u_tag),
            .wr_tgt   (wr_tgt),
            .wr_ctr   (wr_ctr),
            .hit      (hit_v[i]),
            .target   (tgt_v[i*PC_W +: PC_W]),
            .state    (st_v[i*2 +: 2])
        );
    end

    logic [LANE_W-1:0] first;

    // Lowest-numbered taken lane; younger lanes are squashed by fetch.
    always_comb begin
        first = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit_v[i])
                first = LANE_W'(i);
        end
    end

    assign bus.hit        = hit_v;
    assign bus.target     = tgt_v;
    assign bus.state      = st_v;
    assign bus.any_hit    = |hit_v;
    assign bus.first_lane = first;
endmodule
